lmc1992_mw_receiver: RTL and testbench

//   Receiving end of the STE MicroWire link; the shifter is the transmitter.

---
 rtl/lmc1992_mw_receiver.sv | 109 ++++++++++
 tb/tb_lmc1992_mw_receiver.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lmc1992_mw_receiver.sv
// rtl/lmc1992_mw_receiver.sv - MicroWire receiver decoding LMC1992 volume/tone commands
// Deserialises mw_clk/mw_data frames framed by mw_en and registers the decoded controls.
module lmc1992_mw_receiver #(
  parameter logic [1:0] DEV_ADDR  = 2'b10,
  parameter int         FRAME_LEN = 11
) (
  input  logic       clk32,
  input  logic       resb,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_en,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] treble,
  output logic [3:0] bass,
  output logic [1:0] mix,
  output logic       upd,
  output logic       frm_err
);

  localparam logic [4:0] MIN_BITS = 5'(FRAME_LEN);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  logic [1:0]  rst_sync;
  logic        rst_n;
  logic        clk_q, clk_q_d, data_q, en_q, en_q_d;
  logic [10:0] sr;
  logic [4:0]  cnt;
  logic        clk_rise, en_rise, en_fall;
  logic [2:0]  func;
  logic [5:0]  val;
  logic [5:0]  val_m, val_lr, val_tone;

  // Reset asserts asynchronously but is released on a clk32 edge.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      clk_q   <= 1'b0;
      clk_q_d <= 1'b0;
      data_q  <= 1'b0;
      en_q    <= 1'b0;
      en_q_d  <= 1'b0;
    end else begin
      clk_q   <= mw_clk;
      clk_q_d <= clk_q;
      data_q  <= mw_data;
      en_q    <= mw_en;
      en_q_d  <= en_q;
    end
  end

  assign clk_rise = clk_q & ~clk_q_d;
  assign en_rise  = en_q & ~en_q_d;
  assign en_fall  = en_q_d & ~en_q;

  assign func     = sr[8:6];
  assign val      = sr[5:0];
  assign val_m    = (val > 6'd40) ? 6'd40 : val;
  assign val_lr   = (val > 6'd20) ? 6'd20 : val;
  assign val_tone = (val > 6'd12) ? 6'd12 : val;

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      cnt        <= '0;
      master_vol <= 6'd40;
      left_vol   <= 5'd20;
      right_vol  <= 5'd20;
      treble     <= 4'd6;
      bass       <= 4'd6;
      mix        <= 2'd1;
      upd        <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      upd     <= 1'b0;
      frm_err <= 1'b0;
      // A bit clock coinciding with the enable fall sees en_q=0 and is dropped.
      if (en_rise) begin
        sr  <= '0;
        cnt <= '0;
      end else if (clk_rise && en_q) begin
        sr <= {sr[9:0], data_q};
        if (cnt != CNT_MAX) cnt <= cnt + 5'd1;
      end
      if (en_fall) begin
        if (cnt < MIN_BITS) begin
          frm_err <= 1'b1;
        end else if (sr[10:9] == DEV_ADDR) begin
          case (func)
            3'b011: begin master_vol <= val_m;          upd <= 1'b1; end
            3'b101: begin left_vol   <= val_lr[4:0];    upd <= 1'b1; end
            3'b100: begin right_vol  <= val_lr[4:0];    upd <= 1'b1; end
            3'b010: begin treble     <= val_tone[3:0];  upd <= 1'b1; end
            3'b001: begin bass       <= val_tone[3:0];  upd <= 1'b1; end
            3'b000: begin mix        <= val[1:0];       upd <= 1'b1; end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_lmc1992_mw_receiver.sv
// tb/tb_lmc1992_mw_receiver.sv - directed self-checking bench for lmc1992_mw_receiver
module tb_lmc1992_mw_receiver;

  logic       clk32 = 1'b0;
  logic       resb;
  logic       mw_clk, mw_data, mw_en;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] treble, bass;
  logic [1:0] mix;
  logic       upd, frm_err;

  int checks   = 0;
  int failures = 0;
  int n_upd, n_err, upd_at, err_at;

  lmc1992_mw_receiver dut (
    .clk32(clk32), .resb(resb), .mw_clk(mw_clk), .mw_data(mw_data), .mw_en(mw_en),
    .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
    .treble(treble), .bass(bass), .mix(mix), .upd(upd), .frm_err(frm_err)
  );

  always #16 clk32 = ~clk32;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk32);
  endtask

  // Sends the low n bits of v MSB first; fused puts the last bit-clock rise
  // on the same edge as the enable fall. Then watches 8 cycles for pulses.
  task automatic frame(input logic [15:0] v, input int n, input bit fused);
    mw_en = 1'b1; mw_clk = 1'b0;
    cycles(3);
    for (int i = 0; i < n; i++) begin
      mw_data = v[n-1-i];
      mw_clk  = 1'b0;
      cycles(2);
      mw_clk = 1'b1;
      if (fused && i == n - 1) break;
      cycles(2);
    end
    if (!fused) begin
      mw_clk = 1'b0;
      cycles(2);
    end
    mw_en = 1'b0;
    n_upd = 0; n_err = 0; upd_at = -1; err_at = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk32);
      if (upd === 1'b1)     begin n_upd++; if (upd_at < 0) upd_at = c; end
      if (frm_err === 1'b1) begin n_err++; if (err_at < 0) err_at = c; end
    end
    mw_clk = 1'b0;
    cycles(2);
  endtask

  task automatic chk_all(input string tag, input int m, input int l, input int r,
                         input int t, input int b, input int x);
    chk({tag, ".master"}, master_vol, m);
    chk({tag, ".left"},   left_vol,   l);
    chk({tag, ".right"},  right_vol,  r);
    chk({tag, ".treble"}, treble,     t);
    chk({tag, ".bass"},   bass,       b);
    chk({tag, ".mix"},    mix,        x);
  endtask

  initial begin
    resb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_en = 1'b0;
    cycles(4);
    chk_all("reset", 40, 20, 20, 6, 6, 1);
    chk("reset.upd", upd, 0);
    chk("reset.frm_err", frm_err, 0);
    resb = 1'b1;
    cycles(4);

    frame(16'h04C0, 11, 0);
    chk("m0.master", master_vol, 0);
    chk("m0.upd_n", n_upd, 1);

    frame(16'h04E8, 11, 0);
    chk("m40.master", master_vol, 40);
    chk("m40.upd_n", n_upd, 1);
    chk("m40.upd_at", upd_at, 2);
    chk("m40.err_n", n_err, 0);

    frame(16'h0545, 11, 0);
    chk("l5.left", left_vol, 5);
    frame(16'h0554, 11, 0);
    chk("l20.left", left_vol, 20);
    frame(16'h050A, 11, 0);
    chk("r10.right", right_vol, 10);
    frame(16'h053F, 11, 0);
    chk("r63.right", right_vol, 20);
    frame(16'h04BF, 11, 0);
    chk("t63.treble", treble, 12);
    frame(16'h0443, 11, 0);
    chk("b3.bass", bass, 3);
    frame(16'h0402, 11, 0);
    chk("mix2.mix", mix, 2);
    chk("mix2.upd_n", n_upd, 1);

    frame(16'hF4C0, 16, 0);
    chk("f16.master", master_vol, 0);
    chk("f16.upd_n", n_upd, 1);

    frame(16'h00FF, 8, 0);
    chk("short.err_n", n_err, 1);
    chk("short.err_at", err_at, 2);
    chk("short.upd_n", n_upd, 0);
    chk_all("short", 0, 20, 20, 12, 3, 2);

    frame(16'h02E8, 11, 0);
    chk("addr.upd_n", n_upd, 0);
    chk("addr.err_n", n_err, 0);
    chk_all("addr", 0, 20, 20, 12, 3, 2);

    frame(16'h0581, 11, 0);
    chk("f110.upd_n", n_upd, 0);
    chk("f110.err_n", n_err, 0);
    chk_all("f110", 0, 20, 20, 12, 3, 2);

    mw_en = 1'b1;
    cycles(3);
    for (int i = 0; i < 5; i++) begin
      mw_data = 1'b1; mw_clk = 1'b0; cycles(2);
      mw_clk = 1'b1; cycles(2);
    end
    resb = 1'b0;
    cycles(2);
    chk_all("midrst", 40, 20, 20, 6, 6, 1);
    mw_en = 1'b0; mw_clk = 1'b0;
    cycles(2);
    resb = 1'b1;
    n_upd = 0; n_err = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk32);
      if (upd === 1'b1) n_upd++;
      if (frm_err === 1'b1) n_err++;
    end
    chk("midrst.pulses", n_upd + n_err, 0);

    frame(16'h04A8, 11, 0);
    chk("post.master", master_vol, 40);
    chk("post.treble", treble, 12);
    chk("post.upd_n", n_upd, 1);

    frame(16'h04C0, 11, 1);
    chk("fused.err_n", n_err, 1);
    chk("fused.upd_n", n_upd, 0);
    chk("fused.master", master_vol, 40);

    n_upd = 0; n_err = 0;
    for (int i = 0; i < 20; i++) begin
      mw_data = i[0]; mw_clk = ~mw_clk;
      @(negedge clk32);
      if (upd === 1'b1) n_upd++;
      if (frm_err === 1'b1) n_err++;
      @(negedge clk32);
      if (upd === 1'b1) n_upd++;
      if (frm_err === 1'b1) n_err++;
    end
    chk("idle.pulses", n_upd + n_err, 0);
    chk_all("idle", 40, 20, 20, 12, 6, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
